leds_pwm: RTL and testbench
===========================

LEDS_PWM -- requirements
Module: leds_pwm

Interface
REQ-001 Parameter LED_W, default 24: number of LED outputs, legal range 1..32.
REQ-002 Parameter DATA_W, default 16: bus data width, fixed at 16 for register-map compatibility.
REQ-003 Parameter PWM_BITS, default 8: width of the PWM counter and the duty field, legal range 1..8.
REQ-004 Parameter BLINK_BASE, default 10: divider bit index that selects blink rate 0.
REQ-005 led_clk  input  1  single clock; all state changes on its rising edge.
REQ-006 ledrst  input  1  reset, synchronous, active-low.
REQ-007 ledcs  input  1  chip select from address decode.
REQ-008 ledwrite  input  1  write strobe, qualified by ledcs.
REQ-009 ledread  input  1  read strobe, qualified by ledcs.
REQ-010 ledaddr  input  3  register word address.
REQ-011 ledwdata  input  DATA_W  write data.
REQ-012 ledrdata  output  DATA_W  combinational readback data.
REQ-013 ledout  output  LED_W  registered LED drive.

Function
REQ-014 Register map:
- 0 VAL_LO: val[15:0]
- 1 VAL_HI: val[31:16]
- 2 BLK_LO: blink mask[15:0]
- 3 BLK_HI: blink mask[31:16]
- 4 CTRL: [7:0] duty, [11:8] rate, [12] en
- 5 STATUS: read-only, [7:0] pwm_cnt, [8] phase
- 6, 7: reserved
REQ-015 Register bits at or above LED_W in VAL and BLK, duty bits at or above PWM_BITS, and CTRL[15:13] SHALL not be stored and SHALL read as 0.
REQ-016 A write SHALL occur on a rising edge with ledcs=1 and ledwrite=1; the new value SHALL be visible in ledrdata in the following cycle.
REQ-017 Writes with ledcs=0 SHALL be ignored; writes to addresses 5..7 SHALL be ignored.
REQ-018 When ledcs=1 and ledread=1, ledrdata SHALL return the addressed register; otherwise ledrdata SHALL be 0, and reads of addresses 6..7 SHALL return 0.
REQ-019 When write and read are asserted in the same cycle, ledrdata SHALL return the pre-write value.
REQ-020 pwm_cnt SHALL be a PWM_BITS-bit free-running counter, incrementing every cycle and wrapping from 2^PWM_BITS-1 to 0.
REQ-021 pwm_on SHALL be 1 when duty equals all-ones, otherwise (pwm_cnt < duty); duty=0 SHALL give pwm_on=0 permanently.
REQ-022 div SHALL be a (BLINK_BASE+16)-bit free-running counter that wraps.
REQ-023 phase SHALL equal div[BLINK_BASE+rate], so rate 0 gives a 2^(BLINK_BASE+1)-cycle blink period.
REQ-024 On each rising edge, ledout[i] SHALL be loaded with en & val[i] & pwm_on & (~blk[i] | phase).
REQ-025 Register-to-output latency SHALL be 1 cycle: a register written at edge k SHALL affect ledout at edge k+1.
REQ-026 A rate change SHALL take effect immediately, with no resynchronisation of div.
REQ-027 A duty change mid-PWM-period SHALL apply from the next compare, with no resynchronisation of pwm_cnt.
REQ-028 With en=0, ledout SHALL be all 0 while the counters keep running.

Reset
REQ-029 On a rising edge with ledrst=0, the block SHALL set val=0, blk=0, duty=all-ones, rate=0, en=1, pwm_cnt=0, div=0, and ledout=0.
REQ-030 Reset SHALL override a simultaneous write.
REQ-031 After reset, a write to VAL SHALL drive ledout directly with 1-cycle latency (legacy-compatible behaviour).
REQ-032 Reset asserted mid-operation SHALL zero ledout at that edge, regardless of the blink or PWM state.

Verification
REQ-033 Legacy path: reset, then write VAL_LO=0xA5A5 and VAL_HI=0x00C3 -> ledout=0xC3A5A5 one cycle after the second write; readback of addr 1 = 0x00C3.
REQ-034 PWM: duty=0x40, val=0xFFFFFF, over 256 cycles -> each LED is high for exactly 64 cycles; duty=0 -> 0 cycles high; duty=0xFF -> 256 cycles high.
REQ-035 Blink: BLINK_BASE=2, rate=1, BLK_LO=0x0001, val=0x000003 -> bit0 toggles every 8 cycles, bit1 stays high.
REQ-036 Bus rules:
- write with ledcs=0 -> no change
- write to addr 5 -> no change
- simultaneous read/write of addr 0 -> old value returned
- read addr 7 -> 0
- VAL_HI bits [15:8] read as 0 when LED_W=24
REQ-037 Reset mid-operation: ledrst=0 asserted during a blink-on phase together with a VAL write -> ledout=0 at that edge, registers return to reset values, and the write is discarded.
REQ-038 Parameter sweep: LED_W=8 with PWM_BITS=4 -> VAL_HI reads 0, the PWM period is 16 cycles, and duty=0xF gives always-on.

Source files
------------

// File: rtl/leds_pwm.sv
// rtl/leds_pwm.sv - LED driver with per-LED enable, blink mask and global PWM dimming
module leds_pwm #(
  parameter int LED_W      = 24,
  parameter int DATA_W     = 16,
  parameter int PWM_BITS   = 8,
  parameter int BLINK_BASE = 10
) (
  input  logic              led_clk,
  input  logic              ledrst,
  input  logic              ledcs,
  input  logic              ledwrite,
  input  logic              ledread,
  input  logic [2:0]        ledaddr,
  input  logic [DATA_W-1:0] ledwdata,
  output logic [DATA_W-1:0] ledrdata,
  output logic [LED_W-1:0]  ledout
);

  localparam int DIV_W = BLINK_BASE + 16;
  localparam int IDX_W = $clog2(DIV_W);

  localparam logic [2:0] A_VAL_LO = 3'd0;
  localparam logic [2:0] A_VAL_HI = 3'd1;
  localparam logic [2:0] A_BLK_LO = 3'd2;
  localparam logic [2:0] A_BLK_HI = 3'd3;
  localparam logic [2:0] A_CTRL   = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;

  logic [LED_W-1:0]    val;
  logic [LED_W-1:0]    blk;
  logic [PWM_BITS-1:0] duty;
  logic [3:0]          rate;
  logic                en;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    div;

  logic [15:0]      wd;
  logic [15:0]      rd;
  logic             wr_en;
  logic             pwm_on;
  logic             phase;
  logic [IDX_W-1:0] phase_idx;
  logic [31:0]      val_ext;
  logic [31:0]      blk_ext;

  assign wd        = ledwdata[15:0];
  assign wr_en     = ledcs & ledwrite;
  assign val_ext   = 32'(val);
  assign blk_ext   = 32'(blk);
  // All-ones duty means fully on; otherwise on while the counter is below duty.
  assign pwm_on    = (&duty) | (pwm_cnt < duty);
  assign phase_idx = IDX_W'(BLINK_BASE) + IDX_W'(rate);
  assign phase     = div[phase_idx];
  assign ledrdata  = DATA_W'(rd);

  // Register file writes; each LED bit picks its half-word from VAL_LO/HI or BLK_LO/HI.
  always_ff @(posedge led_clk) begin
    if (!ledrst) begin
      val  <= '0;
      blk  <= '0;
      duty <= '1;
      rate <= 4'd0;
      en   <= 1'b1;
    end else if (wr_en) begin
      for (int i = 0; i < LED_W; i++) begin
        if ((i < 16) ? (ledaddr == A_VAL_LO) : (ledaddr == A_VAL_HI)) begin
          val[i] <= wd[i % 16];
        end
        if ((i < 16) ? (ledaddr == A_BLK_LO) : (ledaddr == A_BLK_HI)) begin
          blk[i] <= wd[i % 16];
        end
      end
      if (ledaddr == A_CTRL) begin
        duty <= wd[PWM_BITS-1:0];
        rate <= wd[11:8];
        en   <= wd[12];
      end
    end
  end

  // Free-running PWM and blink dividers, only cleared by reset.
  always_ff @(posedge led_clk) begin
    if (!ledrst) begin
      pwm_cnt <= '0;
      div     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      div     <= div + 1'b1;
    end
  end

  // LED drive: enabled, selected, PWM on, and either not blinking or in the on phase.
  always_ff @(posedge led_clk) begin
    if (!ledrst) begin
      ledout <= '0;
    end else begin
      ledout <= {LED_W{en & pwm_on}} & val & (~blk | {LED_W{phase}});
    end
  end

  // Readback mux; returns current (pre-write) contents, zero when not selected.
  always_comb begin
    rd = 16'h0000;
    if (ledcs && ledread) begin
      case (ledaddr)
        A_VAL_LO: rd = val_ext[15:0];
        A_VAL_HI: rd = val_ext[31:16];
        A_BLK_LO: rd = blk_ext[15:0];
        A_BLK_HI: rd = blk_ext[31:16];
        A_CTRL:   rd = {3'b000, en, rate, 8'(duty)};
        A_STATUS: rd = {7'b0000000, phase, 8'(pwm_cnt)};
        default:  rd = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_leds_pwm.sv
// tb/tb_leds_pwm.sv - directed self-checking bench for leds_pwm
module tb_leds_pwm;

  logic        led_clk = 1'b0;
  logic        ledrst;
  logic        cs_a, cs_b;
  logic        ledwrite, ledread;
  logic [2:0]  ledaddr;
  logic [15:0] ledwdata;
  logic [15:0] rdata_a, rdata_b;
  logic [23:0] out_a;
  logic [7:0]  out_b;

  int checks   = 0;
  int failures = 0;

  always #5 led_clk = ~led_clk;

  leds_pwm #(.LED_W(24), .DATA_W(16), .PWM_BITS(8), .BLINK_BASE(2)) dut_a (
    .led_clk(led_clk), .ledrst(ledrst), .ledcs(cs_a), .ledwrite(ledwrite),
    .ledread(ledread), .ledaddr(ledaddr), .ledwdata(ledwdata),
    .ledrdata(rdata_a), .ledout(out_a)
  );

  leds_pwm #(.LED_W(8), .DATA_W(16), .PWM_BITS(4), .BLINK_BASE(10)) dut_b (
    .led_clk(led_clk), .ledrst(ledrst), .ledcs(cs_b), .ledwrite(ledwrite),
    .ledread(ledread), .ledaddr(ledaddr), .ledwdata(ledwdata),
    .ledrdata(rdata_b), .ledout(out_b)
  );

  task automatic tick();
    @(posedge led_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input bit b, input logic [2:0] a, input logic [15:0] d);
    cs_a = !b; cs_b = b; ledwrite = 1'b1; ledaddr = a; ledwdata = d;
    tick();
    cs_a = 1'b0; cs_b = 1'b0; ledwrite = 1'b0;
  endtask

  task automatic bus_rd(input bit b, input logic [2:0] a, output logic [15:0] d);
    cs_a = !b; cs_b = b; ledread = 1'b1; ledaddr = a;
    #1;
    d = b ? rdata_b : rdata_a;
    cs_a = 1'b0; cs_b = 1'b0; ledread = 1'b0;
  endtask

  task automatic count_a(input int n, output int hi, output int lo);
    hi = 0; lo = 0;
    for (int j = 0; j < n; j++) begin
      if (out_a === 24'hFFFFFF) hi++;
      if (out_a === 24'h000000) lo++;
      tick();
    end
  endtask

  task automatic count_b(input int n, output int hi, output int lo);
    hi = 0; lo = 0;
    for (int j = 0; j < n; j++) begin
      if (out_b === 8'hFF) hi++;
      if (out_b === 8'h00) lo++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r, s1, s2;
    int hi, lo, t, bad, b1ok, found;
    logic bs [48];

    ledrst = 1'b0; cs_a = 1'b0; cs_b = 1'b0; ledwrite = 1'b0; ledread = 1'b0;
    ledaddr = 3'd0; ledwdata = 16'h0000;
    tick(); tick(); tick();

    // Reset state
    chk("rst_out_a", 32'(out_a), 32'h0);
    chk("rst_out_b", 32'(out_b), 32'h0);
    bus_rd(0, 3'd4, r); chk("rst_ctrl_a", 32'(r), 32'h10FF);
    bus_rd(1, 3'd4, r); chk("rst_ctrl_b", 32'(r), 32'h100F);
    bus_rd(0, 3'd5, r); chk("rst_status_a", 32'(r), 32'h0);
    ledrst = 1'b1;

    // Legacy path
    bus_wr(0, 3'd0, 16'hA5A5);
    bus_wr(0, 3'd1, 16'h00C3);
    chk("legacy_latency", 32'(out_a), 32'h00A5A5);
    tick();
    chk("legacy_out", 32'(out_a), 32'hC3A5A5);
    bus_rd(0, 3'd1, r); chk("legacy_rd_hi", 32'(r), 32'h00C3);

    // Bus rules
    cs_a = 1'b0; ledwrite = 1'b1; ledaddr = 3'd0; ledwdata = 16'h1234;
    tick(); ledwrite = 1'b0;
    bus_rd(0, 3'd0, r); chk("nocs_write", 32'(r), 32'hA5A5);
    bus_wr(0, 3'd5, 16'hFFFF);
    bus_rd(0, 3'd4, r); chk("addr5_ctrl", 32'(r), 32'h10FF);
    bus_rd(0, 3'd0, r); chk("addr5_val", 32'(r), 32'hA5A5);
    cs_a = 1'b1; ledwrite = 1'b1; ledread = 1'b1; ledaddr = 3'd0; ledwdata = 16'h5A5A;
    #1; chk("rw_old_value", 32'(rdata_a), 32'hA5A5);
    tick(); cs_a = 1'b0; ledwrite = 1'b0; ledread = 1'b0;
    bus_rd(0, 3'd0, r); chk("rw_new_value", 32'(r), 32'h5A5A);
    bus_rd(0, 3'd7, r); chk("rd_addr7", 32'(r), 32'h0);
    bus_rd(0, 3'd6, r); chk("rd_addr6", 32'(r), 32'h0);
    cs_a = 1'b1; ledaddr = 3'd0; #1;
    chk("no_read_strobe", 32'(rdata_a), 32'h0);
    cs_a = 1'b0;
    bus_wr(0, 3'd1, 16'hFFC3);
    bus_rd(0, 3'd1, r); chk("valhi_upper_zero", 32'(r), 32'h00C3);
    bus_wr(0, 3'd4, 16'hFFFF);
    bus_rd(0, 3'd4, r); chk("ctrl_upper_zero", 32'(r), 32'h1FFF);

    // Enable off: outputs zero, counters keep running
    bus_wr(0, 3'd4, 16'h00FF);
    tick();
    chk("en0_out", 32'(out_a), 32'h0);
    bus_rd(0, 3'd5, s1); tick(); bus_rd(0, 3'd5, s2);
    chk("en0_cnt_runs", 32'((s2[7:0] - s1[7:0]) & 8'hFF), 32'h1);
    bus_wr(0, 3'd4, 16'h10FF);
    tick();
    chk("en1_out", 32'(out_a), 32'hC35A5A);

    // PWM
    bus_wr(0, 3'd0, 16'hFFFF);
    bus_wr(0, 3'd1, 16'hFFFF);
    bus_wr(0, 3'd4, 16'h1040);
    tick();
    count_a(256, hi, lo);
    chk("pwm40_hi", 32'(hi), 32'd64);
    chk("pwm40_lo", 32'(lo), 32'd192);
    bus_wr(0, 3'd4, 16'h1000);
    tick();
    count_a(256, hi, lo);
    chk("pwm00_hi", 32'(hi), 32'd0);
    bus_wr(0, 3'd4, 16'h10FF);
    tick();
    count_a(256, hi, lo);
    chk("pwmff_hi", 32'(hi), 32'd256);

    // Blink: BLINK_BASE=2, rate=1 -> 16-cycle period
    bus_wr(0, 3'd4, 16'h11FF);
    bus_wr(0, 3'd2, 16'h0001);
    bus_wr(0, 3'd0, 16'h0003);
    bus_wr(0, 3'd1, 16'h0000);
    tick();
    b1ok = 0;
    for (int j = 0; j < 48; j++) begin
      bs[j] = out_a[0];
      if (out_a[1] === 1'b1 && out_a[23:2] === 22'h0) b1ok++;
      tick();
    end
    t = -1;
    for (int j = 1; j < 48; j++) begin
      if (t < 0 && bs[j] !== bs[j-1]) t = j;
    end
    chk("blink_first_toggle", 32'(t >= 1 && t <= 9), 32'd1);
    bad = 0;
    if (t >= 1) begin
      for (int j = t; j < 48; j++) begin
        if (bs[j] !== (bs[t] ^ (((j - t) / 8) % 2 == 1))) bad++;
      end
    end
    chk("blink_period8", 32'(bad), 32'd0);
    chk("blink_bit1_steady", 32'(b1ok), 32'd48);

    // Reset mid-operation during blink-on phase with a simultaneous write
    found = 0;
    for (int j = 0; j < 32; j++) begin
      if (found == 0 && out_a[0] === 1'b1) found = 1;
      if (found == 0) tick();
    end
    chk("blink_on_found", 32'(found), 32'd1);
    ledrst = 1'b0; cs_a = 1'b1; ledwrite = 1'b1; ledaddr = 3'd0; ledwdata = 16'hFFFF;
    tick();
    cs_a = 1'b0; ledwrite = 1'b0;
    chk("midrst_out", 32'(out_a), 32'h0);
    bus_rd(0, 3'd5, r); chk("midrst_status", 32'(r), 32'h0);
    ledrst = 1'b1;
    bus_rd(0, 3'd0, r); chk("midrst_val_lo", 32'(r), 32'h0);
    bus_rd(0, 3'd2, r); chk("midrst_blk_lo", 32'(r), 32'h0);
    bus_rd(0, 3'd4, r); chk("midrst_ctrl", 32'(r), 32'h10FF);
    tick();
    chk("midrst_out_after", 32'(out_a), 32'h0);

    // Parameter sweep: LED_W=8, PWM_BITS=4
    bus_wr(1, 3'd1, 16'hFFFF);
    bus_rd(1, 3'd1, r); chk("b_valhi_zero", 32'(r), 32'h0);
    bus_wr(1, 3'd0, 16'hFFFF);
    bus_rd(1, 3'd0, r); chk("b_vallo", 32'(r), 32'h00FF);
    bus_wr(1, 3'd4, 16'h10FF);
    bus_rd(1, 3'd4, r); chk("b_ctrl_duty4", 32'(r), 32'h100F);
    tick();
    count_b(32, hi, lo);
    chk("b_dutyF_always_on", 32'(hi), 32'd32);
    bus_wr(1, 3'd4, 16'h1008);
    tick();
    count_b(16, hi, lo);
    chk("b_duty8_hi", 32'(hi), 32'd8);
    chk("b_duty8_lo", 32'(lo), 32'd8);
    bus_rd(1, 3'd5, s1);
    for (int j = 0; j < 16; j++) tick();
    bus_rd(1, 3'd5, s2);
    chk("b_period16", 32'(s2[3:0]), 32'(s1[3:0]));
    chk("b_cnt_width", 32'(s2[7:4]), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
